alu_muldiv_unit: RTL and testbench
==================================

// Module: alu_muldiv_unit
// PURPOSE
//   Parametrised execute-stage ALU for the pipelined core. Adds arithmetic
//   shift, unsigned compare, and an iterative unsigned multiply/divide unit.
//   Results are registered behind a valid/ready handshake, so the hazard unit
//   can stall the pipeline while a multi-cycle op is in flight.
//   Sits in EX, between the operand-forwarding muxes and the EX/MEM register.
// PARAMETERS
//   XLEN     32                 operand/result width (>=8, power of two)
//   SHAMT_W  $clog2(XLEN)       shift-amount bits taken from b[SHAMT_W-1:0] (derived, do not override)
//   CNT_W    $clog2(XLEN)+1     iteration counter width (derived)
// PORTS
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   flush      in   1     synchronous abort of any op in flight or held result
//   in_valid   in   1     operands/op valid
//   in_ready   out  1     unit can accept (state IDLE)
//   op         in   4     operation select (encoding below)
//   a          in   XLEN  operand A
//   b          in   XLEN  operand B
//   out_valid  out  1     result/zero/illegal valid (state DONE)
//   out_ready  in   1     consumer takes result
//   result     out  XLEN  registered result
//   zero       out  1     result == 0 (true equality only; no sign term)
//   illegal    out  1     op was 4'b1110/4'b1111
// BEHAVIOUR
//   Reset: state=IDLE; result=0, zero=0, illegal=0, out_valid=0, counter=0.
//     in_ready=1 once rst_n deasserts. Reset mid-op discards everything.
//   Op encoding:
//     0000 ADD   0001 SUB   0010 AND   0011 OR    0100 SRL   0101 SLT (signed)
//     0110 XOR   0111 SLL   1000 SRA   1001 SLTU  1010 MUL (low XLEN)
//     1011 MULHU (high XLEN of unsigned 2*XLEN product)
//     1100 DIVU  1101 REMU  1110/1111 illegal -> result=0, illegal=1
//   All arithmetic is modulo 2^XLEN. SLT/SLTU return 1 or 0 in bit 0.
//   FSM IDLE -> (accept: in_valid & in_ready):
//     op 0000-1001 or illegal: go to DONE next edge; out_valid 1 cycle after accept.
//     op 1010-1101: latch a, b, op; go to BUSY; counter=XLEN.
//   BUSY: one shift-add (MUL*) or restoring shift-subtract (DIV*) step per cycle.
//     Counter decrements; at counter==1 go to DONE.
//     Out_valid is XLEN+1 cycles after accept. Inputs are ignored; in_ready=0.
//   DONE: result/zero/illegal stable while out_valid=1 and out_ready=0.
//     out_ready=1 -> IDLE next edge. Back-to-back ops need 1 idle cycle;
//     no overlap in this generation.
//   Divide by zero: runs the full XLEN steps; DIVU -> all ones, REMU -> a. No trap.
//   flush=1: state -> IDLE, out_valid=0 next edge, in-flight op discarded.
//     flush has priority over accept and over out_ready in the same cycle.
//   in_valid while in_ready=0: ignored; the producer must hold its op.
// TESTING
//   1 Reset: rst_n low mid-BUSY (MUL) -> outputs 0, in_ready=1 after release, no stray out_valid.
//   2 ADD a=32'hFFFF_FFFF b=1 -> result 0, zero=1, out_valid 1 cycle after accept;
//     SRA a=32'h8000_0000 b=4 -> 32'hF800_0000; SLT a=-1 b=1 -> 1; SLTU same -> 0.
//   3 MUL a=32'h0001_0000 b=32'h0001_0000 -> 0, zero=1; MULHU same -> 32'h0000_0001;
//     out_valid exactly 33 cycles after accept; in_ready=0 throughout.
//   4 DIVU a=100 b=7 -> 14; REMU -> 2; DIVU a=5 b=0 -> 32'hFFFF_FFFF; REMU a=5 b=0 -> 5.
//   5 Backpressure: hold out_ready=0 for 5 cycles in DONE -> result stable, in_ready=0;
//     new in_valid is not accepted.
//   6 flush at BUSY cycle 10 of DIVU -> IDLE next edge, no out_valid; following ADD 2+3 -> 5.
//     Op 4'b1111 -> result 0, illegal=1.

Source files
------------

// File: rtl/alu_muldiv_unit.sv
// Execute-stage ALU with iterative unsigned multiply/divide.
// Results are held in a registered valid/ready output stage.
module alu_muldiv_unit #(
    parameter int XLEN = 32,
    localparam int SHAMT_W = $clog2(XLEN),
    localparam int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic [SHAMT_W-1:0] shamt;
    logic [XLEN-1:0]    alu_res;
    logic               alu_ill;
    logic               is_multi;
    logic               is_mul_in;
    logic               is_mul_q;

    logic [XLEN:0]      mul_sum;
    logic [XLEN:0]      div_sh;
    logic [XLEN:0]      div_diff;
    logic               div_ok;
    logic [XLEN-1:0]    step_hi;
    logic [XLEN-1:0]    step_lo;
    logic [XLEN-1:0]    fin_res;

    assign shamt     = b[SHAMT_W-1:0];
    assign is_mul_in = (op[3:1] == 3'b101);
    assign is_multi  = is_mul_in || (op[3:1] == 3'b110);
    assign is_mul_q  = (op_q[3:1] == 3'b101);

    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SRL:  alu_res = a >> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
            default: alu_ill = (op[3:1] == 3'b111);
        endcase
    end

    // Multiply: {hi,lo} holds partial product over the shifting multiplier.
    // Divide: hi is the remainder, lo shifts dividend out and quotient in.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {hi_q, lo_q[XLEN-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        div_ok   = ~div_diff[XLEN];
        if (is_mul_q) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            step_hi = div_ok ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ok};
        end
        fin_res = op_q[0] ? step_hi : step_lo;
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_multi) begin
                            state_d = S_BUSY;
                            cnt_d   = CNT_W'(XLEN);
                            op_d    = op;
                            hi_d    = '0;
                            opnd_d  = is_mul_in ? a : b;
                            lo_d    = is_mul_in ? b : a;
                        end else begin
                            state_d   = S_DONE;
                            result_d  = alu_res;
                            zero_d    = (alu_res == '0);
                            illegal_d = alu_ill;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_d = cnt_q - 1'b1;
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d   = S_DONE;
                        result_d  = fin_res;
                        zero_d    = (fin_res == '0);
                        illegal_d = 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Scoreboard bench for alu_muldiv_unit: ALU ops, mul/div, backpressure,
// flush, reset mid-operation and back-to-back traffic.
module tb_alu_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [3:0]      op = 4'd0;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    alu_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        logic [63:0] p;
        p = {32'd0, x} * {32'd0, y};
        e.ill = 1'b0;
        e.res = '0;
        case (o)
            4'd0:  e.res = x + y;
            4'd1:  e.res = x - y;
            4'd2:  e.res = x & y;
            4'd3:  e.res = x | y;
            4'd4:  e.res = x >> y[4:0];
            4'd5:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd6:  e.res = x ^ y;
            4'd7:  e.res = x << y[4:0];
            4'd8:  e.res = $unsigned($signed(x) >>> y[4:0]);
            4'd9:  e.res = (x < y) ? 32'd1 : 32'd0;
            4'd10: e.res = p[31:0];
            4'd11: e.res = p[63:32];
            4'd12: e.res = (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd13: e.res = (y == 0) ? x : x % y;
            default: e.ill = 1'b1;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    function automatic int lat_of(input logic [3:0] o);
        return (o >= 4'd10 && o <= 4'd13) ? 33 : 1;
    endfunction

    // Called at a negedge with the DUT idle; returns just after the accept edge.
    task automatic send(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; in_valid = 1'b1;
        sb.push_back(model(o, x, y));
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n, output bit rdy_seen);
        n = 0;
        rdy_seen = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (in_ready) rdy_seen = 1'b1;
        end while (!out_valid && n < 200);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int n;
        bit rdy;
        bit stray;
        exp_t e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (result !== 0 || zero !== 0 || illegal !== 0 || out_valid !== 0) begin
            errors++;
            $display("FAIL reset_state: res=%h z=%b ill=%b v=%b, want 0 0 0 0", result, zero, illegal, out_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b, want 1", in_ready);
        end
        send(4'd0, 32'd1, 32'd2);
        wait_valid(n, rdy);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1 || n != 1 || result !== e.res) begin
            errors++;
            $display("FAIL reset_pre_add: v=%b lat=%0d res=%h, want 1 1 %h", out_valid, n, result, e.res);
        end
        take();
        op = 4'd10; a = 32'h1234_5678; b = 32'h0000_0100; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: in_ready=%b, want 0", in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (result !== 0 || zero !== 0 || illegal !== 0 || out_valid !== 0) begin
            errors++;
            $display("FAIL reset_midop: res=%h z=%b ill=%b v=%b, want 0 0 0 0", result, zero, illegal, out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, want 1", in_ready);
        end
        stray = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL reset_stray_valid: out_valid seen=1, want 0");
        end
    endtask

    task automatic test_alu();
        logic [3:0]  ops[10] = '{4'd0, 4'd8, 4'd5, 4'd9, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd7};
        logic [31:0] as[10] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd3, 32'hF0F0_1234, 32'h0F00_0001, 32'h8000_0000,
                                32'hAAAA_5555, 32'h0000_0003};
        logic [31:0] bs[10] = '{32'd1, 32'd4, 32'd1, 32'd1, 32'd5, 32'h0FF0_FF00,
                                32'h00F0_0010, 32'd31, 32'hFFFF_0000, 32'd30};
        int n;
        bit rdy;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            send(ops[i], as[i], bs[i]);
            wait_valid(n, rdy);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1 || n != 1 || rdy || result !== e.res || zero !== e.z || illegal !== e.ill) begin
                errors++;
                $display("FAIL alu_op%0h: v=%b lat=%0d rdy=%b res=%h z=%b ill=%b, want 1 1 0 %h %b %b",
                         ops[i], out_valid, n, rdy, result, zero, illegal, e.res, e.z, e.ill);
            end
            take();
        end
    endtask

    task automatic test_muldiv();
        logic [3:0]  ops[9] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd12, 4'd13, 4'd10, 4'd11, 4'd12};
        logic [31:0] as[9] = '{32'h0001_0000, 32'h0001_0000, 32'd100, 32'd100, 32'd5, 32'd5,
                               32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hFFFF_FFF0};
        logic [31:0] bs[9] = '{32'h0001_0000, 32'h0001_0000, 32'd7, 32'd7, 32'd0, 32'd0,
                               32'h1357_9BDF, 32'hFFFF_FFFF, 32'h0000_0013};
        int n;
        bit rdy;
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            send(ops[i], as[i], bs[i]);
            wait_valid(n, rdy);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1 || n != 33 || rdy || result !== e.res || zero !== e.z || illegal !== e.ill) begin
                errors++;
                $display("FAIL muldiv_op%0h: v=%b lat=%0d rdy=%b res=%h z=%b ill=%b, want 1 33 0 %h %b %b",
                         ops[i], out_valid, n, rdy, result, zero, illegal, e.res, e.z, e.ill);
            end
            take();
        end
    endtask

    task automatic test_backpressure();
        int n;
        bit rdy;
        bit bad;
        bit stray;
        exp_t e;
        send(4'd0, 32'd7, 32'd8);
        wait_valid(n, rdy);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            op = 4'd1; a = 32'd100 + i; b = 32'd1; in_valid = 1'b1;
            @(negedge clk);
            if (out_valid !== 1 || in_ready !== 0 || result !== 32'd15) bad = 1'b1;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bad || result !== e.res || zero !== e.z) begin
            errors++;
            $display("FAIL backpressure_hold: unstable=%b res=%h z=%b, want 0 %h %b", bad, result, zero, e.res, e.z);
        end
        take();
        stray = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (out_valid || !in_ready) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL backpressure_ignored_input: activity seen=1, want 0");
        end
    endtask

    task automatic test_flush();
        int n;
        bit rdy;
        bit stray;
        exp_t e;
        op = 4'd12; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 0 || in_ready !== 1) begin
            errors++;
            $display("FAIL flush_busy: v=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        stray = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stray = 1'b1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL flush_stray_valid: out_valid seen=1, want 0");
        end
        op = 4'd0; a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 0 || in_ready !== 1) begin
            errors++;
            $display("FAIL flush_over_accept: v=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        send(4'd0, 32'd2, 32'd3);
        wait_valid(n, rdy);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1 || n != 1 || result !== 32'd5 || result !== e.res) begin
            errors++;
            $display("FAIL flush_then_add: v=%b lat=%0d res=%h, want 1 1 00000005", out_valid, n, result);
        end
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 0 || in_ready !== 1) begin
            errors++;
            $display("FAIL flush_in_done: v=%b rdy=%b, want 0 1", out_valid, in_ready);
        end
        for (int i = 14; i < 16; i++) begin
            send(4'(i), 32'h1234_5678, 32'h9ABC_DEF0);
            wait_valid(n, rdy);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1 || n != 1 || result !== e.res || illegal !== 1'b1 || zero !== e.z) begin
                errors++;
                $display("FAIL illegal_op%0h: v=%b lat=%0d res=%h ill=%b z=%b, want 1 1 00000000 1 %b",
                         i, out_valid, n, result, illegal, zero, e.z);
            end
            take();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        int n;
        bit rdy;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            o = 4'($urandom_range(0, 15));
            x = $urandom;
            y = (i % 4 == 3) ? 32'($urandom_range(0, 40)) : $urandom;
            send(o, x, y);
            wait_valid(n, rdy);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1 || n != lat_of(o) || result !== e.res || zero !== e.z || illegal !== e.ill) begin
                errors++;
                $display("FAIL b2b_op%0h a=%h b=%h: v=%b lat=%0d res=%h z=%b ill=%b, want 1 %0d %h %b %b",
                         o, x, y, out_valid, n, result, zero, illegal, lat_of(o), e.res, e.z, e.ill);
            end
            take();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_muldiv();
        test_backpressure();
        test_flush();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
